// File: rtl/lnrv_exu_wbck.sv
// GPR writeback arbiter: merges ALU/LSU/MDV results onto one register-file write port,
// pairing in-order MDV results with destination tags captured at issue time.
module lnrv_exu_wbck #(
  parameter int MDV_OSTD   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        alu_wbck_vld,
  output logic        alu_wbck_rdy,
  input  logic [31:0] alu_wbck_wdata,
  input  logic [4:0]  alu_wbck_rdidx,
  input  logic        lsu_wbck_vld,
  output logic        lsu_wbck_rdy,
  input  logic [31:0] lsu_wbck_wdata,
  input  logic [4:0]  lsu_wbck_rdidx,
  input  logic        mdv_issue_vld,
  output logic        mdv_issue_rdy,
  input  logic [4:0]  mdv_issue_rdidx,
  input  logic        mdv_wbck_vld,
  output logic        mdv_wbck_rdy,
  input  logic [31:0] mdv_wbck_wdata,
  output logic        mdv_busy,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);
  localparam int PW = (MDV_OSTD > 1) ? $clog2(MDV_OSTD) : 1;
  localparam int CW = $clog2(MDV_OSTD + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX  = SW'(STARVE_MAX);
  localparam logic [CW-1:0] DEPTH = CW'(MDV_OSTD);
  localparam logic [PW-1:0] LAST  = PW'(MDV_OSTD - 1);

  logic [4:0]    tag_mem [MDV_OSTD];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] tag_cnt;
  logic [SW-1:0] lsu_cnt, mdv_cnt;

  logic fifo_empty, fifo_full, lsu_e, mdv_e, push, pop;
  logic grant_alu, grant_lsu, grant_mdv, grant_any;
  logic [4:0]  win_idx;
  logic [31:0] win_data;

  assign fifo_empty = (tag_cnt == '0);
  assign fifo_full  = (tag_cnt == DEPTH);
  assign lsu_e      = lsu_wbck_vld;
  assign mdv_e      = mdv_wbck_vld & ~fifo_empty;

  // Starved requesters outrank the ALU; LSU wins ties between two starved ports.
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    grant_mdv = 1'b0;
    if (lsu_e && lsu_cnt == SMAX)      grant_lsu = 1'b1;
    else if (mdv_e && mdv_cnt == SMAX) grant_mdv = 1'b1;
    else if (alu_wbck_vld)             grant_alu = 1'b1;
    else if (lsu_e)                    grant_lsu = 1'b1;
    else if (mdv_e)                    grant_mdv = 1'b1;
  end

  always_comb begin
    win_idx  = alu_wbck_rdidx;
    win_data = alu_wbck_wdata;
    if (grant_lsu) begin
      win_idx  = lsu_wbck_rdidx;
      win_data = lsu_wbck_wdata;
    end else if (grant_mdv) begin
      win_idx  = tag_mem[rd_ptr];
      win_data = mdv_wbck_wdata;
    end
  end

  assign grant_any     = grant_alu | grant_lsu | grant_mdv;
  assign alu_wbck_rdy  = grant_alu;
  assign lsu_wbck_rdy  = grant_lsu;
  assign mdv_wbck_rdy  = grant_mdv;
  assign mdv_issue_rdy = ~fifo_full;
  assign mdv_busy      = ~fifo_empty;
  assign push          = mdv_issue_vld & ~fifo_full;
  assign pop           = grant_mdv;

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= mdv_issue_rdidx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tag_cnt  <= '0;
      lsu_cnt  <= '0;
      mdv_cnt  <= '0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase

      if (lsu_e && !grant_lsu) lsu_cnt <= (lsu_cnt == SMAX) ? SMAX : lsu_cnt + 1'b1;
      else                     lsu_cnt <= '0;
      if (mdv_e && !grant_mdv) mdv_cnt <= (mdv_cnt == SMAX) ? SMAX : mdv_cnt + 1'b1;
      else                     mdv_cnt <= '0;

      // Writes to x0 complete the handshake but never reach the register file.
      rf_wen <= grant_any && (win_idx != 5'd0);
      if (grant_any && win_idx != 5'd0) begin
        rf_waddr <= win_idx;
        rf_wdata <= win_data;
      end
    end
  end
endmodule
